// File: rtl/beam_combiner.sv
// Three-to-one AXI-Stream packet combiner with per-packet source
// selection (round-robin or fixed) and a one-stage output register.
module beam_combiner #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        src_sel,
  input  logic [DWIDTH-1:0] axis_S_ch1_tdata,
  input  logic              axis_S_ch1_tvalid,
  output logic              axis_S_ch1_tready,
  input  logic              axis_S_ch1_tlast,
  input  logic [DWIDTH-1:0] axis_S_ch2_tdata,
  input  logic              axis_S_ch2_tvalid,
  output logic              axis_S_ch2_tready,
  input  logic              axis_S_ch2_tlast,
  input  logic [DWIDTH-1:0] axis_S_ch3_tdata,
  input  logic              axis_S_ch3_tvalid,
  output logic              axis_S_ch3_tready,
  input  logic              axis_S_ch3_tlast,
  output logic [DWIDTH-1:0] axis_M_sink_tdata,
  output logic              axis_M_sink_tvalid,
  input  logic              axis_M_sink_tready,
  output logic              axis_M_sink_tlast,
  output logic [1:0]        grant
);

  localparam logic [0:0] ARB  = 1'b0;
  localparam logic [0:0] PASS = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [1:0]        grant_q, grant_d;
  logic              rr_mode_q, rr_mode_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic              valid_q, valid_d;

  logic [3:0]        vld4;
  logic [DWIDTH-1:0] g_data;
  logic              g_valid;
  logic              g_last;
  logic              g_ready;
  logic              accept;
  logic [1:0]        c0, c1, c2;
  logic [1:0]        rr_pick;
  logic              rr_hit;

  function automatic logic [1:0] nxt(input logic [1:0] c);
    return (c == 2'd3) ? 2'd1 : c + 2'd1;
  endfunction

  // Slot 0 is the "no channel" code and is never valid.
  assign vld4 = {axis_S_ch3_tvalid, axis_S_ch2_tvalid,
                 axis_S_ch1_tvalid, 1'b0};

  assign c0 = rr_ptr_q;
  assign c1 = nxt(c0);
  assign c2 = nxt(c1);

  always_comb begin
    rr_hit  = 1'b1;
    rr_pick = c0;
    if (vld4[c0]) begin
      rr_pick = c0;
    end else if (vld4[c1]) begin
      rr_pick = c1;
    end else if (vld4[c2]) begin
      rr_pick = c2;
    end else begin
      rr_hit = 1'b0;
    end
  end

  always_comb begin
    g_data  = '0;
    g_valid = 1'b0;
    g_last  = 1'b0;
    unique case (1'b1)
      grant_q == 2'd1: begin
        g_data  = axis_S_ch1_tdata;
        g_valid = axis_S_ch1_tvalid;
        g_last  = axis_S_ch1_tlast;
      end
      grant_q == 2'd2: begin
        g_data  = axis_S_ch2_tdata;
        g_valid = axis_S_ch2_tvalid;
        g_last  = axis_S_ch2_tlast;
      end
      grant_q == 2'd3: begin
        g_data  = axis_S_ch3_tdata;
        g_valid = axis_S_ch3_tvalid;
        g_last  = axis_S_ch3_tlast;
      end
      default: begin
        g_data  = '0;
        g_valid = 1'b0;
        g_last  = 1'b0;
      end
    endcase
  end

  assign g_ready = (state_q == PASS)
                 & (~valid_q | axis_M_sink_tready);
  assign accept  = g_ready & g_valid;

  assign axis_S_ch1_tready = g_ready & (grant_q == 2'd1);
  assign axis_S_ch2_tready = g_ready & (grant_q == 2'd2);
  assign axis_S_ch3_tready = g_ready & (grant_q == 2'd3);

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    rr_mode_d = rr_mode_q;
    data_d    = data_q;
    last_d    = last_q;
    valid_d   = valid_q;

    if (accept) begin
      valid_d = 1'b1;
      data_d  = g_data;
      last_d  = g_last;
    end else if (valid_q && axis_M_sink_tready) begin
      valid_d = 1'b0;
    end

    unique case (1'b1)
      state_q == ARB: begin
        if (src_sel == 2'b00) begin
          if (rr_hit) begin
            grant_d   = rr_pick;
            rr_mode_d = 1'b1;
            state_d   = PASS;
          end
        end else if (vld4[src_sel]) begin
          grant_d   = src_sel;
          rr_mode_d = 1'b0;
          state_d   = PASS;
        end
      end
      state_q == PASS: begin
        if (accept && g_last) begin
          state_d = ARB;
          grant_d = 2'd0;
          if (rr_mode_q) begin
            rr_ptr_d = nxt(grant_q);
          end
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ARB;
      rr_ptr_q  <= 2'd1;
      grant_q   <= 2'd0;
      rr_mode_q <= 1'b0;
      data_q    <= '0;
      last_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      rr_mode_q <= rr_mode_d;
      data_q    <= data_d;
      last_q    <= last_d;
      valid_q   <= valid_d;
    end
  end

  assign axis_M_sink_tdata  = data_q;
  assign axis_M_sink_tvalid = valid_q;
  assign axis_M_sink_tlast  = last_q;
  assign grant              = grant_q;

endmodule

// File: tb/tb_beam_combiner.sv
// Scoreboard bench for beam_combiner: per-channel source queues,
// expected sink beats queued in predicted arbitration order.
module tb_beam_combiner;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;
  typedef beat_t bq_t[$];

  logic        clk;
  logic        rst;
  logic [1:0]  src_sel;
  logic [31:0] s_tdata [3];
  logic        s_tvalid[3];
  logic        s_tlast [3];
  logic        s_tready[3];
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic [1:0]  grant;

  bq_t   srcq[3];
  beat_t exp_q[$];

  int tests_run;
  int tests_failed;
  int cyc;
  int sink_beats;
  int rdy_viol;
  int stab_viol;
  int gap_err;
  bit gap_on;
  bit have_prev;
  bit prev_last;
  int last_cyc;
  bit bp_en;
  bit hold;
  beat_t hold_b;
  logic [1:0]  gprev;
  logic [31:0] gsig;

  beam_combiner #(.DWIDTH(32)) dut (
    .clk                (clk),
    .rst                (rst),
    .src_sel            (src_sel),
    .axis_S_ch1_tdata   (s_tdata[0]),
    .axis_S_ch1_tvalid  (s_tvalid[0]),
    .axis_S_ch1_tready  (s_tready[0]),
    .axis_S_ch1_tlast   (s_tlast[0]),
    .axis_S_ch2_tdata   (s_tdata[1]),
    .axis_S_ch2_tvalid  (s_tvalid[1]),
    .axis_S_ch2_tready  (s_tready[1]),
    .axis_S_ch2_tlast   (s_tlast[1]),
    .axis_S_ch3_tdata   (s_tdata[2]),
    .axis_S_ch3_tvalid  (s_tvalid[2]),
    .axis_S_ch3_tready  (s_tready[2]),
    .axis_S_ch3_tlast   (s_tlast[2]),
    .axis_M_sink_tdata  (m_tdata),
    .axis_M_sink_tvalid (m_tvalid),
    .axis_M_sink_tready (m_tready),
    .axis_M_sink_tlast  (m_tlast),
    .grant              (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic run_src(input int c);
    bit hs;
    forever begin
      @(negedge clk);
      hs = s_tvalid[c] && s_tready[c];
      @(posedge clk);
      #1;
      if (hs && srcq[c].size() > 0)
        void'(srcq[c].pop_front());
      if (srcq[c].size() > 0) begin
        s_tvalid[c] = 1'b1;
        s_tdata[c]  = srcq[c][0].data;
        s_tlast[c]  = srcq[c][0].last;
      end else begin
        s_tvalid[c] = 1'b0;
        s_tdata[c]  = '0;
        s_tlast[c]  = 1'b0;
      end
    end
  endtask

  task automatic load(input int c, input logic [31:0] base,
                      input int n);
    for (int i = 0; i < n; i++)
      srcq[c].push_back('{base + 32'(i), i == n - 1});
  endtask

  task automatic expect_pkt(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back('{base + 32'(i), i == n - 1});
  endtask

  task automatic wait_drain(input int budget, output int left);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    left = exp_q.size();
  endtask

  task automatic flush_all();
    @(posedge clk);
    #2;
    for (int c = 0; c < 3; c++) begin
      srcq[c].delete();
      s_tvalid[c] = 1'b0;
      s_tlast[c]  = 1'b0;
      s_tdata[c]  = '0;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Sink monitor: scoreboard pop, stability, gaps, grant order.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        hold  = 1'b0;
        gprev = 2'd0;
        continue;
      end
      if (grant != 2'd0 && gprev == 2'd0)
        gsig = {gsig[29:0], grant};
      gprev = grant;
      for (int c = 0; c < 3; c++)
        if (s_tready[c] && grant != 2'(c + 1))
          rdy_viol++;
      if (hold) begin
        if (!m_tvalid || m_tdata !== hold_b.data ||
            m_tlast !== hold_b.last)
          stab_viol++;
      end
      hold   = m_tvalid && !m_tready;
      hold_b = '{m_tdata, m_tlast};
      if (m_tvalid && m_tready) begin
        sink_beats++;
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL sink_beat: got %h/%b, want no beat",
                   m_tdata, m_tlast);
        end else begin
          e = exp_q.pop_front();
          if (m_tdata !== e.data || m_tlast !== e.last) begin
            tests_failed++;
            $display("FAIL sink_beat: got %h/%b, want %h/%b",
                     m_tdata, m_tlast, e.data, e.last);
          end
        end
        if (gap_on) begin
          if (have_prev &&
              cyc - last_cyc != (prev_last ? 2 : 1))
            gap_err++;
          have_prev = 1'b1;
          prev_last = m_tlast;
          last_cyc  = cyc;
        end
      end
    end
  end

  task automatic test_reset();
    #2;
    tests_run++;
    if (grant !== 2'd0 || m_tvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_gv: grant=%0d valid=%b, want 0/0",
               grant, m_tvalid);
    end
    tests_run++;
    if (m_tdata !== 32'h0 || m_tlast !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_dl: data=%h last=%b, want 0/0",
               m_tdata, m_tlast);
    end
    tests_run++;
    if (s_tready[0] !== 1'b0 || s_tready[1] !== 1'b0 ||
        s_tready[2] !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_rdy: ready=%b%b%b, want 000",
               s_tready[0], s_tready[1], s_tready[2]);
    end
    @(posedge clk);
    #3;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    tests_run++;
    if (grant !== 2'd0 || m_tvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle: grant=%0d valid=%b, want 0/0",
               grant, m_tvalid);
    end
  endtask

  task automatic test_fixed_ch2();
    int left;
    src_sel = 2'b10;
    gsig = '0;
    load(0, 32'h100, 4);
    load(1, 32'h200, 4);
    load(2, 32'h300, 4);
    expect_pkt(32'h200, 4);
    wait_drain(100, left);
    tests_run++;
    if (left !== 0) begin
      tests_failed++;
      $display("FAIL fixed_drain: left=%0d, want 0", left);
    end
    tests_run++;
    if (gsig !== 32'h2) begin
      tests_failed++;
      $display("FAIL fixed_grant: seq=%h, want 2", gsig);
    end
    tests_run++;
    if (srcq[0].size() !== 4 || srcq[2].size() !== 4) begin
      tests_failed++;
      $display("FAIL fixed_others: ch1=%0d ch3=%0d, want 4/4",
               srcq[0].size(), srcq[2].size());
    end
    flush_all();
  endtask

  task automatic test_rr_rotation();
    int left;
    src_sel = 2'b00;
    gsig = '0;
    gap_err = 0;
    have_prev = 1'b0;
    gap_on = 1'b1;
    load(0, 32'h100, 3);
    load(0, 32'h110, 3);
    load(1, 32'h200, 3);
    load(1, 32'h210, 3);
    load(2, 32'h300, 3);
    load(2, 32'h310, 3);
    expect_pkt(32'h100, 3);
    expect_pkt(32'h200, 3);
    expect_pkt(32'h300, 3);
    expect_pkt(32'h110, 3);
    expect_pkt(32'h210, 3);
    expect_pkt(32'h310, 3);
    wait_drain(200, left);
    gap_on = 1'b0;
    tests_run++;
    if (left !== 0) begin
      tests_failed++;
      $display("FAIL rr_drain: left=%0d, want 0", left);
    end
    tests_run++;
    if (gsig !== 32'h6db) begin
      tests_failed++;
      $display("FAIL rr_order: seq=%h, want 6db", gsig);
    end
    tests_run++;
    if (gap_err !== 0) begin
      tests_failed++;
      $display("FAIL rr_bubble: gap errors=%0d, want 0", gap_err);
    end
  endtask

  task automatic test_rr_skip();
    int left;
    src_sel = 2'b00;
    gsig = '0;
    load(2, 32'h320, 2);
    expect_pkt(32'h320, 2);
    wait_drain(100, left);
    load(0, 32'h120, 2);
    load(2, 32'h330, 2);
    expect_pkt(32'h120, 2);
    expect_pkt(32'h330, 2);
    wait_drain(100, left);
    tests_run++;
    if (left !== 0) begin
      tests_failed++;
      $display("FAIL skip_drain: left=%0d, want 0", left);
    end
    tests_run++;
    if (gsig !== 32'h37) begin
      tests_failed++;
      $display("FAIL skip_order: seq=%h, want 37", gsig);
    end
  endtask

  task automatic test_backpressure();
    int left;
    src_sel = 2'b01;
    stab_viol = 0;
    bp_en = 1'b1;
    load(0, 32'h400, 8);
    expect_pkt(32'h400, 8);
    wait_drain(400, left);
    bp_en = 1'b0;
    repeat (2) @(posedge clk);
    tests_run++;
    if (left !== 0) begin
      tests_failed++;
      $display("FAIL bp_drain: left=%0d, want 0", left);
    end
    tests_run++;
    if (stab_viol !== 0) begin
      tests_failed++;
      $display("FAIL bp_stable: changes=%0d, want 0", stab_viol);
    end
  endtask

  task automatic test_select_change();
    int left;
    int n;
    src_sel = 2'b01;
    gsig = '0;
    load(0, 32'h500, 4);
    load(2, 32'h530, 2);
    expect_pkt(32'h500, 4);
    expect_pkt(32'h530, 2);
    n = 0;
    while (grant !== 2'd1 && n < 50) begin
      @(posedge clk);
      n++;
    end
    tests_run++;
    if (n >= 50) begin
      tests_failed++;
      $display("FAIL sel_grant: grant=%0d, want 1", grant);
    end
    @(posedge clk);
    #2;
    src_sel = 2'b11;
    wait_drain(100, left);
    tests_run++;
    if (left !== 0) begin
      tests_failed++;
      $display("FAIL sel_drain: left=%0d, want 0", left);
    end
    tests_run++;
    if (gsig !== 32'h7) begin
      tests_failed++;
      $display("FAIL sel_order: seq=%h, want 7", gsig);
    end
  endtask

  task automatic test_reset_mid();
    int left;
    int n;
    int base;
    src_sel = 2'b00;
    load(0, 32'h600, 1);
    expect_pkt(32'h600, 1);
    wait_drain(50, left);
    base = sink_beats;
    load(1, 32'h700, 8);
    expect_pkt(32'h700, 8);
    n = 0;
    while (sink_beats < base + 3 && n < 50) begin
      @(posedge clk);
      n++;
    end
    tests_run++;
    if (n >= 50) begin
      tests_failed++;
      $display("FAIL rmid_start: beats=%0d, want 3",
               sink_beats - base);
    end
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    tests_run++;
    if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 ||
        m_tdata !== 32'h0 || grant !== 2'd0) begin
      tests_failed++;
      $display("FAIL rmid_out: v=%b l=%b d=%h g=%0d, want 0",
               m_tvalid, m_tlast, m_tdata, grant);
    end
    tests_run++;
    if (s_tready[0] !== 1'b0 || s_tready[1] !== 1'b0 ||
        s_tready[2] !== 1'b0) begin
      tests_failed++;
      $display("FAIL rmid_rdy: ready=%b%b%b, want 000",
               s_tready[0], s_tready[1], s_tready[2]);
    end
    for (int c = 0; c < 3; c++) begin
      srcq[c].delete();
      s_tvalid[c] = 1'b0;
      s_tlast[c]  = 1'b0;
    end
    exp_q.delete();
    @(posedge clk);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #2;
    tests_run++;
    if (grant !== 2'd0) begin
      tests_failed++;
      $display("FAIL rmid_grant: grant=%0d, want 0", grant);
    end
    gsig = '0;
    load(1, 32'h720, 1);
    load(0, 32'h620, 1);
    expect_pkt(32'h620, 1);
    expect_pkt(32'h720, 1);
    wait_drain(50, left);
    tests_run++;
    if (left !== 0) begin
      tests_failed++;
      $display("FAIL rmid_drain: left=%0d, want 0", left);
    end
    tests_run++;
    if (gsig !== 32'h6) begin
      tests_failed++;
      $display("FAIL rmid_order: seq=%h, want 6", gsig);
    end
  endtask

  initial begin
    rst = 1'b0;
    src_sel = 2'b00;
    m_tready = 1'b1;
    bp_en = 1'b0;
    gap_on = 1'b0;
    tests_run = 0;
    tests_failed = 0;
    cyc = 0;
    sink_beats = 0;
    rdy_viol = 0;
    stab_viol = 0;
    gap_err = 0;
    gsig = '0;
    gprev = 2'd0;
    for (int c = 0; c < 3; c++) begin
      s_tdata[c]  = '0;
      s_tvalid[c] = 1'b0;
      s_tlast[c]  = 1'b0;
    end
    fork
      run_src(0);
      run_src(1);
      run_src(2);
    join_none
    test_reset();
    test_fixed_ch2();
    test_rr_rotation();
    test_rr_skip();
    test_backpressure();
    test_select_change();
    test_reset_mid();
    tests_run++;
    if (rdy_viol !== 0) begin
      tests_failed++;
      $display("FAIL ready_grant: stray readies=%0d, want 0",
               rdy_viol);
    end
    $display("[TB] %0d tests run, %0d failed",
             tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/beam_combiner.md
# beam_combiner

Three-to-one AXI-Stream packet combiner, the return-path counterpart of the beam demux. Merges three channel-side streams (ch1..ch3, one per DAC/ADC lane) into a single sink stream toward the modulator/capture path. The source is chosen per packet (tlast-delimited) by `src_sel`: round-robin or a fixed channel. Unlike the demux, the combiner supports full backpressure on every port.

## Interface

**Parameters**
- `DWIDTH`, default 32: tdata width of all streams.

**Ports**
- `clk` in 1: single clock; all logic is synchronous to its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `src_sel` in 2: 00 round-robin, 01 ch1, 10 ch2, 11 ch3. Sampled only at arbitration.
- `axis_S_ch1_tdata` in DWIDTH: channel 1 data. Channels 2 and 3 are identical.
- `axis_S_ch1_tvalid` in 1: channel 1 valid.
- `axis_S_ch1_tready` out 1: channel 1 ready.
- `axis_S_ch1_tlast` in 1: channel 1 end of packet.
- `axis_S_ch2_*`, `axis_S_ch3_*`: same set of four signals as ch1.
- `axis_M_sink_tdata` out DWIDTH: merged data.
- `axis_M_sink_tvalid` out 1: merged valid.
- `axis_M_sink_tready` in 1: merged ready.
- `axis_M_sink_tlast` out 1: merged end of packet.
- `grant` out 2: channel currently owning the output. 0 means none, 1..3 is the channel.

## Operation

**Reset** (rst=0, asynchronous)
- FSM goes to ARB.
- `rr_ptr` is set to 1.
- `grant` = 0.
- All `tready` = 0.
- `axis_M_sink_tvalid` = 0, `tlast` = 0, `tdata` = 0.
- Deassertion takes effect on the next rising edge.

**FSM states:** ARB and PASS.

**ARB** (all input treadys 0)
- Samples `src_sel`.
- Fixed mode (01/10/11): if the selected channel's tvalid = 1, set `grant` to that channel and go to PASS. Otherwise stay in ARB. Other channels are never granted, even if valid.
- Round-robin (00): search channels in the order rr_ptr, rr_ptr+1, rr_ptr+2, wrapping 3 → 1. Grant the first one with tvalid = 1 and go to PASS. If none is valid, stay in ARB.

**PASS**
- Only the granted channel's tready may be high.
- `tready_g` = !M_tvalid || M_tready (one-stage output register).
- On an accepted beat (`tvalid_g` && `tready_g`), register tdata and tlast into the output and set M_tvalid = 1.
- When M_tvalid && M_tready with no new beat accepted, M_tvalid goes to 0.
- When the accepted beat has tlast = 1:
  - go to ARB and set `grant` = 0;
  - in round-robin mode, set rr_ptr = granted channel + 1, wrapping 3 → 1.
  - In fixed mode, rr_ptr is unchanged.

**Selection rules**
- The mode is latched for the whole packet. `src_sel` changes during PASS are ignored until the next ARB.
- Packets are never interleaved. Output tlast always corresponds to the tlast of the granted channel.
- A packet with zero data beats is not possible: every packet is at least one beat with tlast = 1.
- All data passes through unmodified; width is DWIDTH end to end.

**Boundary conditions**
- Simultaneous valids in round-robin: rr_ptr priority decides.
- Output stalled (M_tready = 0 while M_tvalid = 1): granted tready = 0 and the output holds stable (AXIS rule: no change of data or tlast while valid && !ready).
- A tlast beat accepted in the same cycle the output drains: the FSM is in ARB on the next cycle. The output register may still hold that beat, and ARB can grant while it is held.
- Reset mid-packet: the partial packet is discarded. The output deasserts asynchronously and any in-flight beat is lost.

## Timing

- Latency: an input beat accepted at edge N appears on the sink at edge N+1 (one register stage).
- Throughput: one beat per clock within a packet when M_tready is held high.
- Arbitration bubble: exactly one ARB cycle between packets. A back-to-back 1-beat packet stream therefore sustains at most one beat per 2 clocks.
- `grant` is registered. It becomes nonzero in the first PASS cycle and returns to 0 in the cycle after the tlast beat is accepted.
- tready outputs are combinational from the state and M_tready/M_tvalid. There are no combinational paths from input tvalid to input tready.

## Test plan

1. **Fixed ch2:** src_sel=10; all three channels send 4-beat packets 0x200..0x203 and similar, M_tready=1. Required: the sink carries only the ch2 data in order; ch1/ch3 tready stay 0; grant=2 during the packet.
2. **Round-robin rotation:** src_sel=00; all channels continuously valid with 3-beat packets. Required: sink packet order ch1, ch2, ch3, ch1; one idle cycle between packets; tlast on every 3rd beat.
3. **Round-robin skip:** src_sel=00; only ch3 valid, then ch1 and ch3 valid. Required: ch3 is granted first, then ch1 (rr_ptr wrapped to 1), then ch3.
4. **Backpressure:** 8-beat packet with M_tready toggled in a random pattern. Required: no beat lost or duplicated; sink data is stable while M_tready = 0; the bench scoreboard matches input order.
5. **Mid-packet select change:** src_sel switched 01 → 11 during beat 2 of a ch1 packet. Required: the ch1 packet completes intact; the next packet comes from ch3.
6. **Reset mid-packet:** assert rst low during beat 3. Required: all outputs go to 0 immediately; after release, grant=0 and rr_ptr=1, so the first round-robin packet comes from ch1.
